pipe_ctrl: RTL



---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/pipe_ctrl_if.sv | 33 +++
 rtl/pipe_ctrl_div_timer.sv | 27 ++
 rtl/pipe_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: stall bit positions and the
// legacy 2-bit controller state encoding.
package pipe_ctrl_pkg;

  localparam int unsigned STALL_PC      = 0;
  localparam int unsigned STALL_IF_ID   = 1;
  localparam int unsigned STALL_ID_EXE  = 2;
  localparam int unsigned STALL_EXE_MEM = 3;

  typedef logic [1:0] ctrl_state_t;

  localparam ctrl_state_t CTRL_IDLE     = 2'd0;
  localparam ctrl_state_t CTRL_DIV_WAIT = 2'd1;
  localparam ctrl_state_t CTRL_REFILL   = 2'd2;

  // Hold every pipeline register from pc up to and including stage idx.
  function automatic logic [3:0] stall_upto(input int unsigned idx);
    logic [3:0] v;
    v = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      v[i] = (i <= idx);
    end
    return v;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/redirect/divider handshake bundle between the pipeline stages and
// pipe_ctrl; the slave modport is the controller's view.
interface pipe_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32
) ();

  logic                  id_stallreq_i;
  logic                  exe_jump_i;
  logic [ADDR_WIDTH-1:0] exe_jump_addr_i;
  logic                  exe_div_req_i;
  logic                  div_done_i;
  logic [3:0]            stall_o;
  logic                  flush_o;
  logic                  jump_o;
  logic [ADDR_WIDTH-1:0] jump_addr_o;
  logic                  div_start_o;
  logic                  div_abort_o;
  logic                  err_o;
  logic [31:0]           stall_cnt_o;

  modport master (
    output id_stallreq_i, exe_jump_i, exe_jump_addr_i, exe_div_req_i, div_done_i,
    input  stall_o, flush_o, jump_o, jump_addr_o, div_start_o, div_abort_o,
           err_o, stall_cnt_o
  );

  modport slave (
    input  id_stallreq_i, exe_jump_i, exe_jump_addr_i, exe_div_req_i, div_done_i,
    output stall_o, flush_o, jump_o, jump_addr_o, div_start_o, div_abort_o,
           err_o, stall_cnt_o
  );

endinterface

// File: rtl/pipe_ctrl_div_timer.sv
// 8-bit divider watchdog: counts enabled cycles since the last clear and
// flags the final allowed cycle.
module pipe_ctrl_div_timer #(
  parameter int unsigned DIV_TIMEOUT = 40
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [7:0] count;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count <= '0;
    end else if (clr_i) begin
      count <= '0;
    end else if (en_i) begin
      count <= count + 8'd1;
    end
  end

  assign expire_o = en_i && (count == 8'(DIV_TIMEOUT - 1));

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: merges load-use, redirect and divider
// requests into one stall vector and flush, plus watchdog and stall counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DIV_TIMEOUT   = 40,
  parameter int unsigned REFILL_CYCLES = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  pipe_ctrl_if.slave   bus
);

  ctrl_state_t           state, state_nxt;
  logic [1:0]            refill_cnt;
  logic                  refill_load;
  logic                  tmr_clr, tmr_en, tmr_expire;
  logic                  err_set, err_q;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [31:0]           stall_cnt;
  logic [3:0]            stall;
  logic                  flush, jump, div_start, div_abort;

  pipe_ctrl_div_timer #(
    .DIV_TIMEOUT(DIV_TIMEOUT)
  ) u_div_timer (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .expire_o(tmr_expire)
  );

  always_comb begin
    state_nxt   = state;
    stall       = '0;
    flush       = 1'b0;
    jump        = 1'b0;
    div_start   = 1'b0;
    div_abort   = 1'b0;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;
    refill_load = 1'b0;
    err_set     = 1'b0;
    case (state)
      CTRL_IDLE: begin
        if (bus.exe_div_req_i) begin
          div_start = 1'b1;
          stall     = stall_upto(STALL_ID_EXE);
          tmr_clr   = 1'b1;
          err_set   = bus.exe_jump_i;
          state_nxt = CTRL_DIV_WAIT;
        end else if (bus.exe_jump_i) begin
          jump  = 1'b1;
          flush = 1'b1;
          if (REFILL_CYCLES > 0) begin
            refill_load = 1'b1;
            state_nxt   = CTRL_REFILL;
          end
        end else if (bus.id_stallreq_i) begin
          stall = stall_upto(STALL_IF_ID);
        end
      end
      CTRL_DIV_WAIT: begin
        tmr_en = 1'b1;
        if (bus.div_done_i) begin
          state_nxt = CTRL_IDLE;
        end else if (tmr_expire) begin
          div_abort = 1'b1;
          err_set   = 1'b1;
          state_nxt = CTRL_IDLE;
        end else begin
          stall = stall_upto(STALL_ID_EXE);
        end
      end
      CTRL_REFILL: begin
        flush = 1'b1;
        if (refill_cnt == 2'd1) begin
          state_nxt = CTRL_IDLE;
        end
      end
      default: state_nxt = CTRL_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= CTRL_IDLE;
      refill_cnt <= '0;
      err_q      <= 1'b0;
      last_addr  <= '0;
      stall_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (refill_load) begin
        refill_cnt <= 2'(REFILL_CYCLES);
      end else if (state == CTRL_REFILL && refill_cnt != 2'd0) begin
        refill_cnt <= refill_cnt - 2'd1;
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
      if (jump) begin
        last_addr <= bus.exe_jump_addr_i;
      end
      if (|stall) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

  // The redirect target is visible in the same cycle as jump_o, then held.
  assign bus.jump_addr_o = jump ? bus.exe_jump_addr_i : last_addr;
  assign bus.stall_o     = stall;
  assign bus.flush_o     = flush;
  assign bus.jump_o      = jump;
  assign bus.div_start_o = div_start;
  assign bus.div_abort_o = div_abort;
  assign bus.err_o       = err_q;
  assign bus.stall_cnt_o = stall_cnt;

endmodule
